// File: rtl/cr_lz77_comp_pkg.sv
// Shared types and defaults for the LZ77 compare tile sequencer.
package cr_lz77_comp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_RUN,
    ST_FLUSH,
    ST_CLEAR
  } tile_seq_state_e;

  localparam int FLUSH_CYC_DEF  = 8;
  localparam int PREFIX_MAX_DEF = 64;

endpackage

// File: rtl/cr_lz77_comp_tile_seq.sv
// Frame sequencer for the LZ77 compare tile chain: prefix load, streaming
// compare, flush and valid clear, with every tile-facing output registered.
module cr_lz77_comp_tile_seq
  import cr_lz77_comp_pkg::*;
#(
  parameter int IN_BYTES   = 4,
  parameter int SHIFT_MULT = 4,
  parameter int PREFIX_MAX = PREFIX_MAX_DEF,
  parameter int FLUSH_CYC  = FLUSH_CYC_DEF,
  localparam int PW        = (SHIFT_MULT > 1) ? $clog2(SHIFT_MULT) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_vld,
  output logic                  o_in_rdy,
  input  logic [IN_BYTES*8-1:0] i_in_data,
  input  logic [IN_BYTES-1:0]   i_in_bvld,
  input  logic                  i_in_sof,
  input  logic                  i_in_eof,
  input  logic                  i_in_prefix,
  input  logic                  i_cl_stall,
  output logic [IN_BYTES*8-1:0] o_lz77_tile_data,
  output logic [IN_BYTES-1:0]   o_lz77_tile_data_vld,
  output logic [IN_BYTES*8-1:0] o_lz77_tile_prefix_data,
  output logic [IN_BYTES-1:0]   o_lz77_tile_prefix_data_vld,
  output logic                  o_prefix_en,
  output logic                  o_input_en,
  output logic                  o_shift_en,
  output logic                  o_me_tile_enable,
  output logic [PW-1:0]         o_shift_start_phase,
  output logic                  o_cl_ti_force_done,
  output logic                  o_cl_ti_clr_valid,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_err_prefix_ovf,
  output logic                  o_err_partial,
  output logic                  o_err_sof
);

  localparam int PCW = $clog2(PREFIX_MAX + 1);
  localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [IN_BYTES-1:0] BVLD_FULL = '1;

  tile_seq_state_e r_state, w_next_state;
  logic [PW-1:0]   r_phase, w_phase_base, w_phase_nxt;
  logic [PCW-1:0]  r_pcnt, w_pcnt_base;
  logic [FCW-1:0]  r_fcnt;

  logic w_rdy, w_accept, w_sof_abort, w_prefix_word, w_data_word;
  logic w_pcnt_full, w_prefix_keep, w_flush_last;
  logic w_me, w_force, w_clr, w_busy, w_err_ovf, w_err_partial, w_err_sof;

  // Ready policy: IDLE only takes a frame start; a SOF inside a frame is held back.
  always_comb begin
    w_rdy = 1'b0;
    case (r_state)
      ST_IDLE:   w_rdy = i_in_vld & i_in_sof;
      ST_PREFIX: w_rdy = ~i_in_sof;
      ST_RUN:    w_rdy = ~i_in_sof & ~i_cl_stall;
      default:   w_rdy = 1'b0;
    endcase
  end

  assign o_in_rdy      = w_rdy;
  assign w_accept      = i_in_vld & w_rdy;
  assign w_sof_abort   = i_in_vld & i_in_sof & ((r_state == ST_PREFIX) | (r_state == ST_RUN));
  assign w_prefix_word = w_accept & i_in_prefix & ((r_state == ST_IDLE) | (r_state == ST_PREFIX));
  assign w_data_word   = w_accept & ~w_prefix_word;

  // A frame start restarts phase and prefix count within the same cycle.
  assign w_phase_base  = (r_state == ST_IDLE) ? '0 : r_phase;
  assign w_pcnt_base   = (r_state == ST_IDLE) ? '0 : r_pcnt;
  assign w_phase_nxt   = (w_phase_base == PW'(SHIFT_MULT - 1)) ? '0 : w_phase_base + PW'(1);
  assign w_pcnt_full   = (w_pcnt_base == PCW'(PREFIX_MAX));
  assign w_prefix_keep = w_prefix_word & ~w_pcnt_full;
  assign w_flush_last  = (r_fcnt == FCW'(FLUSH_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (i_in_eof)         w_next_state = ST_FLUSH;
          else if (i_in_prefix) w_next_state = ST_PREFIX;
          else                  w_next_state = ST_RUN;
        end
      end
      ST_PREFIX, ST_RUN: begin
        if (w_sof_abort) begin
          w_next_state = ST_FLUSH;
        end else if (w_accept) begin
          if (i_in_eof)           w_next_state = ST_FLUSH;
          else if (w_data_word)   w_next_state = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (w_flush_last && !i_cl_stall) w_next_state = ST_CLEAR;
      end
      ST_CLEAR: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_me          = (r_state == ST_PREFIX) | (r_state == ST_RUN) | (r_state == ST_FLUSH);
    w_force       = (r_state == ST_FLUSH) & (r_fcnt == '0);
    w_clr         = (r_state == ST_CLEAR);
    w_busy        = (r_state != ST_IDLE);
    w_err_ovf     = w_prefix_word & w_pcnt_full;
    w_err_partial = w_data_word & (i_in_bvld != BVLD_FULL) & ~i_in_eof;
    w_err_sof     = w_sof_abort | (w_data_word & i_in_prefix);
  end

  // The flush counter saturates on its last value while the stall holds the exit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_pcnt  <= '0;
      r_fcnt  <= '0;
    end else begin
      if (w_data_word)                          r_phase <= w_phase_nxt;
      else if (w_accept && r_state == ST_IDLE)  r_phase <= '0;
      if (w_prefix_keep)                        r_pcnt  <= w_pcnt_base + PCW'(1);
      else if (w_accept && r_state == ST_IDLE)  r_pcnt  <= '0;
      if (r_state != ST_FLUSH)                  r_fcnt  <= '0;
      else if (!w_flush_last)                   r_fcnt  <= r_fcnt + FCW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_lz77_tile_data            <= '0;
      o_lz77_tile_data_vld        <= '0;
      o_lz77_tile_prefix_data     <= '0;
      o_lz77_tile_prefix_data_vld <= '0;
      o_prefix_en                 <= 1'b0;
      o_input_en                  <= 1'b0;
      o_shift_en                  <= 1'b0;
      o_me_tile_enable            <= 1'b0;
      o_shift_start_phase         <= '0;
      o_cl_ti_force_done          <= 1'b0;
      o_cl_ti_clr_valid           <= 1'b0;
      o_busy                      <= 1'b0;
      o_frame_done                <= 1'b0;
      o_err_prefix_ovf            <= 1'b0;
      o_err_partial               <= 1'b0;
      o_err_sof                   <= 1'b0;
    end else begin
      o_prefix_en        <= w_prefix_keep;
      o_input_en         <= w_data_word;
      o_shift_en         <= w_prefix_keep | w_data_word;
      o_me_tile_enable   <= w_me;
      o_cl_ti_force_done <= w_force;
      o_cl_ti_clr_valid  <= w_clr;
      o_busy             <= w_busy;
      o_frame_done       <= w_clr;
      o_err_prefix_ovf   <= w_err_ovf;
      o_err_partial      <= w_err_partial;
      o_err_sof          <= w_err_sof;
      if (w_data_word) begin
        o_lz77_tile_data     <= i_in_data;
        o_lz77_tile_data_vld <= i_in_bvld;
        o_shift_start_phase  <= w_phase_base;
      end
      if (w_prefix_keep) begin
        o_lz77_tile_prefix_data     <= i_in_data;
        o_lz77_tile_prefix_data_vld <= i_in_bvld;
      end
    end
  end

endmodule
